// File: rtl/mips32_pkg.sv
// Shared branch-unit definitions: operation codes, predictor reset value and
// the small helpers used by the branch resolver.
package mips32_pkg;

    localparam logic [3:0] BR_BEQ  = 4'd0;
    localparam logic [3:0] BR_BNE  = 4'd1;
    localparam logic [3:0] BR_BGT  = 4'd2;
    localparam logic [3:0] BR_BLT  = 4'd3;
    localparam logic [3:0] BR_BGE  = 4'd4;
    localparam logic [3:0] BR_BLE  = 4'd5;
    localparam logic [3:0] BR_BGTU = 4'd6;
    localparam logic [3:0] BR_BLTU = 4'd7;
    localparam logic [3:0] BR_JUMP = 4'd8;

    // Weakly not-taken
    localparam logic [1:0] BHT_RESET = 2'b01;

    localparam int MISP_CNT_W = 16;

    typedef struct packed {
        logic taken;
        logic pred_taken;
        logic mispredict;
        logic illegal;
    } br_result_t;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
        logic [1:0] res;
        res = cnt;
        if (up && cnt != 2'b11) begin
            res = cnt + 2'b01;
        end else if (!up && cnt != 2'b00) begin
            res = cnt - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluation and operation-code decode.
module branch_cmp
    import mips32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [3:0]       code,
    output logic             taken,
    output logic             illegal,
    output logic             is_cond
);

    logic eq;
    logic slt;
    logic ult;

    assign eq  = (rs_val == rt_val);
    assign slt = ($signed(rs_val) < $signed(rt_val));
    assign ult = (rs_val < rt_val);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        is_cond = 1'b1;
        case (code)
            BR_BEQ:  taken = eq;
            BR_BNE:  taken = !eq;
            BR_BGT:  taken = !slt && !eq;
            BR_BLT:  taken = slt;
            BR_BGE:  taken = !slt;
            BR_BLE:  taken = slt || eq;
            BR_BGTU: taken = !ult && !eq;
            BR_BLTU: taken = ult;
            BR_JUMP: begin
                taken   = 1'b1;
                is_cond = 1'b0;
            end
            default: begin
                illegal = 1'b1;
                is_cond = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolver with a 2-bit saturating-counter history table and a
// one-deep valid/ready result stage carrying prediction accuracy.
module branch_resolve
    import mips32_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 16,
    parameter int PC_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      rs_val,
    input  logic [WIDTH-1:0]      rt_val,
    input  logic [3:0]            code,
    input  logic [PC_WIDTH-1:0]   pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  taken,
    output logic                  pred_taken,
    output logic                  mispredict,
    output logic                  illegal,
    output logic [MISP_CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic cmp_taken;
    logic cmp_illegal;
    logic cmp_is_cond;

    branch_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .code    (code),
        .taken   (cmp_taken),
        .illegal (cmp_illegal),
        .is_cond (cmp_is_cond)
    );

    logic [1:0]            bht_q [BHT_DEPTH];
    logic [1:0]            bht_d [BHT_DEPTH];
    logic [IDX_W-1:0]      bht_idx;
    logic [1:0]            cnt_rd;
    logic [1:0]            cnt_upd;
    logic                  bht_we;
    logic                  accept;
    logic                  new_pred;
    logic                  new_misp;
    br_result_t            res_q;
    br_result_t            res_d;
    logic                  out_valid_q;
    logic                  out_valid_d;
    logic [MISP_CNT_W-1:0] misp_cnt_q;
    logic [MISP_CNT_W-1:0] misp_cnt_d;
    logic [PC_WIDTH-1:0]   pc_unused;

    // Only the table index bits of the PC matter here.
    assign pc_unused = pc;

    assign in_ready = reset && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign bht_idx = pc[2 +: IDX_W];
    assign cnt_rd  = bht_q[bht_idx];
    assign cnt_upd = sat_update(cnt_rd, cmp_taken);
    assign bht_we  = accept && cmp_is_cond;

    always_comb begin
        new_pred = cnt_rd[1];
        if (cmp_illegal) begin
            new_pred = 1'b0;
        end else if (code == BR_JUMP) begin
            new_pred = 1'b1;
        end
    end

    assign new_misp = !cmp_illegal && (cmp_taken ^ new_pred);

    generate
        for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht_next
            assign bht_d[gi] = (bht_we && bht_idx == IDX_W'(gi)) ? cnt_upd : bht_q[gi];
        end
    endgenerate

    always_comb begin
        res_d       = res_q;
        out_valid_d = out_valid_q;
        misp_cnt_d  = misp_cnt_q;
        if (accept) begin
            res_d.taken      = cmp_taken;
            res_d.pred_taken = new_pred;
            res_d.mispredict = new_misp;
            res_d.illegal    = cmp_illegal;
            out_valid_d      = 1'b1;
            if (new_misp && misp_cnt_q != {MISP_CNT_W{1'b1}}) begin
                misp_cnt_d = misp_cnt_q + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= BHT_RESET;
            end
            res_q       <= '0;
            out_valid_q <= 1'b0;
            misp_cnt_q  <= '0;
        end else begin
            bht_q       <= bht_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            misp_cnt_q  <= misp_cnt_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign taken            = res_q.taken;
    assign pred_taken       = res_q.pred_taken;
    assign mispredict       = res_q.mispredict;
    assign illegal          = res_q.illegal;
    assign mispredict_count = misp_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: the driver queues expected results,
// a monitor pops and compares each one as the DUT hands it over.
module tb_branch_resolve;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [3:0]  code;
    logic [31:0] pc;
    logic        out_valid;
    logic        out_ready;
    logic        taken;
    logic        pred_taken;
    logic        mispredict;
    logic        illegal;
    logic [15:0] mispredict_count;

    typedef struct packed {
        logic        t;
        logic        p;
        logic        m;
        logic        i;
        logic [15:0] c;
    } res_t;

    res_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    branch_resolve #(
        .WIDTH     (32),
        .BHT_DEPTH (16),
        .PC_WIDTH  (32)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .rs_val           (rs_val),
        .rt_val           (rt_val),
        .code             (code),
        .pc               (pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .taken            (taken),
        .pred_taken       (pred_taken),
        .mispredict       (mispredict),
        .illegal          (illegal),
        .mispredict_count (mispredict_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    endtask

    function automatic res_t mk(input logic t, input logic p, input logic m,
                                input logic i, input logic [15:0] c);
        res_t r;
        r.t = t; r.p = p; r.m = m; r.i = i; r.c = c;
        return r;
    endfunction

    task automatic push_exp(input string nm, input res_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic issue(input string nm, input logic [3:0] c, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] p, input res_t e,
                         output int waits);
        @(negedge clock);
        code = c; rs_val = rs; rt_val = rt; pc = p; in_valid = 1'b1;
        waits = 0;
        #1;
        while (!in_ready && waits < 50) begin
            @(negedge clock);
            #1;
            waits++;
        end
        if (!in_ready) begin
            check({nm, "_accept_timeout"}, in_ready, 1);
        end else begin
            push_exp(nm, e);
            @(posedge clock);
        end
    endtask

    // Monitor: a transfer happens on the posedge following a cycle where
    // out_valid && out_ready, so sample mid-cycle.
    initial begin
        res_t  e;
        string nm;
        forever begin
            @(negedge clock);
            #2;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", out_valid, 0);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    $display("txn %s: taken=%0b pred=%0b misp=%0b ill=%0b cnt=%0d",
                             nm, taken, pred_taken, mispredict, illegal, mispredict_count);
                    check({nm, ".taken"}, taken, e.t);
                    check({nm, ".pred_taken"}, pred_taken, e.p);
                    check({nm, ".mispredict"}, mispredict, e.m);
                    check({nm, ".illegal"}, illegal, e.i);
                    check({nm, ".mispredict_count"}, mispredict_count, e.c);
                end
            end
        end
    end

    initial begin
        int w;
        reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        code = 4'd0; rs_val = 0; rt_val = 0; pc = 0;

        repeat (2) @(negedge clock);
        #1;
        check("rst.in_ready", in_ready, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.taken", taken, 0);
        check("rst.pred_taken", pred_taken, 0);
        check("rst.mispredict", mispredict, 0);
        check("rst.illegal", illegal, 0);
        check("rst.count", mispredict_count, 0);
        @(negedge clock);
        reset = 1'b1; in_valid = 1'b0;

        // First touch of pc=0x40 and the signed/unsigned operand pair
        issue("beq40_a", 4'd0, 32'd5, 32'd5, 32'h40, mk(1,0,1,0,1), w);
        issue("beq40_b", 4'd0, 32'd5, 32'd5, 32'h40, mk(1,1,0,0,1), w);
        issue("blt_neg", 4'd3, 32'hFFFFFFFF, 32'd1, 32'h10, mk(1,0,1,0,2), w);
        issue("bltu_big", 4'd7, 32'hFFFFFFFF, 32'd1, 32'h10, mk(0,1,1,0,3), w);

        // Remaining compare codes on index 8
        issue("bgt_neg", 4'd2, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h20, mk(1,0,1,0,4), w);
        issue("bge_eq", 4'd4, 32'd7, 32'd7, 32'h20, mk(1,1,0,0,4), w);
        issue("ble_gt", 4'd5, 32'd8, 32'd7, 32'h20, mk(0,1,1,0,5), w);
        issue("bgtu_msb", 4'd6, 32'h80000000, 32'd1, 32'h20, mk(1,1,0,0,5), w);
        issue("bgt_msb", 4'd2, 32'h80000000, 32'd1, 32'h20, mk(0,1,1,0,6), w);
        issue("jump", 4'd8, 32'd0, 32'd9, 32'h20, mk(1,1,0,0,6), w);
        issue("bne_eq", 4'd1, 32'd3, 32'd3, 32'h20, mk(0,1,1,0,7), w);
        issue("illegal12", 4'd12, 32'd5, 32'd5, 32'h20, mk(0,0,0,1,7), w);
        issue("illegal9", 4'd9, 32'd1, 32'd2, 32'h20, mk(0,0,0,1,7), w);
        issue("blt_a", 4'd3, 32'd1, 32'd2, 32'h20, mk(1,0,1,0,8), w);
        issue("blt_b", 4'd3, 32'd1, 32'd2, 32'h20, mk(1,1,0,0,8), w);

        // Backpressure: request held off while the result is not taken
        issue("hold_x", 4'd0, 32'd0, 32'd0, 32'h40, mk(1,1,0,0,8), w);
        @(negedge clock);
        out_ready = 1'b0;
        code = 4'd1; rs_val = 0; rt_val = 0; pc = 32'h40; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("hold.in_ready", in_ready, 0);
            check("hold.out_valid", out_valid, 1);
            check("hold.taken", taken, 1);
            check("hold.pred_taken", pred_taken, 1);
            check("hold.count", mispredict_count, 8);
            @(negedge clock);
        end
        out_ready = 1'b1;
        #1;
        check("release.in_ready", in_ready, 1);
        push_exp("hold_y", mk(0,1,1,0,9));
        @(posedge clock);
        issue("hold_z", 4'd0, 32'd1, 32'd1, 32'h40, mk(1,1,0,0,9), w);
        check("no_bubble.waits", w, 0);

        // Reset while a result is pending
        @(negedge clock);
        in_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        check("midrst.out_valid", out_valid, 0);
        check("midrst.in_ready", in_ready, 0);
        check("midrst.count", mispredict_count, 0);
        check("midrst.taken", taken, 0);
        @(negedge clock);
        reset = 1'b1;
        issue("post_rst", 4'd0, 32'd2, 32'd2, 32'h40, mk(1,0,1,0,1), w);

        // Saturation at pc=0x80 (shares index 0)
        for (int k = 0; k < 5; k++) begin
            issue($sformatf("sat_t%0d", k), 4'd1, 32'd1, 32'd2, 32'h80, mk(1,1,0,0,1), w);
        end
        issue("sat_nt", 4'd1, 32'd2, 32'd2, 32'h80, mk(0,1,1,0,2), w);
        issue("sat_after", 4'd0, 32'd4, 32'd4, 32'h80, mk(1,1,0,0,2), w);

        @(negedge clock);
        in_valid = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clock);
        #3;
        check("drain.pending", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter BHT_DEPTH, default 16, branch-history-table entries, a power of 2, minimum 2.
REQ-003 SHALL have parameter PC_WIDTH, default 32, program-counter width in bits.
REQ-004 SHALL have port clock  in  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  in  1  a branch request is present.
REQ-007 SHALL have port in_ready  out  1  the block accepts the request this cycle.
REQ-008 SHALL have ports rs_val, rt_val  in  WIDTH each  compare operands.
REQ-009 SHALL have port code  in  4  branch operation code (REQ-014).
REQ-010 SHALL have port pc  in  PC_WIDTH  branch address.
REQ-011 SHALL have port out_valid  out  1  the result registers hold a valid result.
REQ-012 SHALL have port out_ready  in  1  the consumer takes the result.
REQ-013 SHALL have ports taken, pred_taken, mispredict, illegal (out, 1 each) and mispredict_count (out, 16): the result fields.

Function
REQ-014 SHALL decode code as follows.
- 0 beq; 1 bne.
- 2 bgt, 3 blt, 4 bge, 5 ble: signed two's complement.
- 6 bgtu, 7 bltu: unsigned.
- 8 jump: always taken.
- 9-15: taken=0, illegal=1.
REQ-015 SHALL accept a request when in_valid && in_ready, with in_ready = !out_valid || out_ready (combinational).
REQ-016 SHALL register taken, pred_taken, mispredict and illegal on acceptance and assert out_valid on the next cycle (latency 1 cycle).
REQ-017 SHALL hold the result stable while out_valid && !out_ready.
REQ-018 SHALL clear out_valid when the result is taken and no new request is accepted in the same cycle.
REQ-019 SHALL support full throughput: accepting while out_ready=1 replaces the result back-to-back with no bubble.
REQ-020 SHALL index the BHT with pc[2 +: log2(BHT_DEPTH)]; each entry is a 2-bit saturating counter.
REQ-021 SHALL set pred_taken = counter[1] of the indexed entry, read before any update in the acceptance cycle.
REQ-022 SHALL set pred_taken=1 for jump; for illegal codes pred_taken=0 and mispredict=0.
REQ-023 SHALL set mispredict = taken XOR pred_taken, for codes 0-8 only.
REQ-024 SHALL update the indexed counter in the acceptance cycle, for codes 0-7 only: +1 if taken, -1 if not, saturating at 3 and 0.
REQ-025 SHALL give back-to-back requests to the same index the updated counter value on the second request.
REQ-026 SHALL increment mispredict_count on each accepted request that yields mispredict=1, saturating at 16'hFFFF.
REQ-027 SHALL keep the BHT and mispredict_count unchanged for requests that are not accepted (in_valid && !in_ready).

Reset
REQ-028 SHALL, while reset=0, force out_valid=0, taken=0, pred_taken=0, mispredict=0, illegal=0, mispredict_count=0, and all BHT counters to 2'b01 (weakly not-taken).
REQ-029 SHALL discard a pending result and any in-progress request when reset is asserted mid-operation; BHT updates resume from the reset state.
REQ-030 SHALL hold in_ready=0 while reset=0.

Structure
REQ-031 SHALL take branch code constants (BR_BEQ .. BR_JUMP) and the BHT reset value from the shared package mips32_pkg.
REQ-032 SHALL place operand comparison and code decode in one combinational sub-module, branch_cmp (inputs rs_val, rt_val, code; outputs taken, illegal, is_cond).

Verification
REQ-033 SHALL cover: blt, rs_val=32'hFFFFFFFF, rt_val=1 -> taken=1; bltu with the same operands -> taken=0.
REQ-034 SHALL cover: after reset, beq pc=0x40, equal operands -> pred_taken=0, taken=1, mispredict=1, mispredict_count=1; repeat -> pred_taken=1, mispredict=0.
REQ-035 SHALL cover: five taken branches at pc=0x80 -> counter saturates at 3; one not-taken branch -> pred_taken stays 1 on the next request.
REQ-036 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, result held, BHT unchanged; out_ready=1 -> the next request is accepted with no bubble.
REQ-037 SHALL cover: code=12 -> illegal=1, taken=0, mispredict=0, BHT and mispredict_count unchanged.
REQ-038 SHALL cover: reset asserted while out_valid=1 -> out_valid=0 immediately; after release, pc=0x40 predicts 0.
